// File: rtl/ledmatrix_rx_if.sv
// Serial command link into ledmatrix_rx together with its word-level status outputs.
// The master side drives the three serial pins; the slave side is the responder.
interface ledmatrix_rx_if;
    logic        in_serial_clk;
    logic        in_serial_data;
    logic        in_seg_enable;
    logic        out_word_valid;
    logic        out_frame_err;
    logic [15:0] out_word;

    modport master (
        output in_serial_clk,
        output in_serial_data,
        output in_seg_enable,
        input  out_word_valid,
        input  out_frame_err,
        input  out_word
    );

    modport slave (
        input  in_serial_clk,
        input  in_serial_data,
        input  in_seg_enable,
        output out_word_valid,
        output out_frame_err,
        output out_word
    );
endinterface

// File: rtl/ledmatrix_rx.sv
// MAX7219-style serial responder: receives 16-bit command words and drives a scanned, PWM-dimmed LED array.
// Optional macro LEDMAT_RX_SEVENSEG_EN adds the per-digit seven-segment decoder selected by the decode mask.
module ledmatrix_rx #(
    parameter int MAIN_CLK     = 50_000_000,
    parameter int BUS_BITS     = 16,
    parameter int NUM_SEGS     = 8,
    parameter int LEDS_PER_SEG = 8,
    parameter int SCAN_CYCLES  = MAIN_CLK / 8000
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    ledmatrix_rx_if.slave           bus,
    output logic [NUM_SEGS-1:0]     out_rows,
    output logic [LEDS_PER_SEG-1:0] out_cols
);

    localparam int               PHASE_DIV = SCAN_CYCLES / 16;
    localparam int               SUB_W     = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;
    localparam logic [SUB_W-1:0] SUB_MAX   = SUB_W'(PHASE_DIV - 1);
    localparam logic [2:0]       LIMIT_MAX = 3'(NUM_SEGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_e;

    // Synchronisers: bit 0 first stage, bit 1 synchronised, bit 2 previous value for edge detect
    logic [2:0] sclk_q;
    logic [2:0] sen_q;
    logic [1:0] sdat_q;

    logic sclk_rise;
    logic en_fall;
    logic en_lvl;
    logic din;

    state_e              state_q, state_d;
    logic [BUS_BITS-1:0] shreg_q, shreg_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                err_d;

    logic [7:0]              addr;
    logic [7:0]              data;
    logic [LEDS_PER_SEG-1:0] digit_q [NUM_SEGS];
    logic [3:0]              intensity_q;
    logic [2:0]              limit_q;
    logic                    normal_q;
    logic                    test_q;
    logic [BUS_BITS-1:0]     word_q;
    logic                    valid_q;
    logic                    err_q;
`ifdef LEDMAT_RX_SEVENSEG_EN
    logic [NUM_SEGS-1:0]     decode_q;
`endif

    logic [SUB_W-1:0]        sub_q;
    logic [3:0]              phase_q;
    logic [2:0]              idx_q;
    logic                    slot_wrap;
    logic [2:0]              eff_limit;

    logic [LEDS_PER_SEG-1:0] cur_cols;
    logic [NUM_SEGS-1:0]     rows_d, rows_q;
    logic [LEDS_PER_SEG-1:0] cols_d, cols_q;

`ifdef LEDMAT_RX_SEVENSEG_EN
    // Active-high segments, bit 0 = a ... bit 6 = g
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction
`endif

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            sclk_q <= '0;
            sen_q  <= '0;
            sdat_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], bus.in_serial_clk};
            sen_q  <= {sen_q[1:0], bus.in_seg_enable};
            sdat_q <= {sdat_q[0], bus.in_serial_data};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign en_fall   = ~sen_q[1] & sen_q[2];
    assign en_lvl    = sen_q[1];
    assign din       = sdat_q[1];

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Enable fall wins over a coincident serial-clock edge, so that edge is dropped
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_lvl) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (en_fall) begin
                    if (cnt_q >= 5'd16) begin
                        state_d = ST_LATCH;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (sclk_rise) begin
                    shreg_d = {shreg_q[BUS_BITS-2:0], din};
                    if (cnt_q != 5'd17) begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            ST_LATCH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign addr = shreg_q[BUS_BITS-1 -: 8];
    assign data = shreg_q[7:0];

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            for (int i = 0; i < NUM_SEGS; i++) begin
                digit_q[i] <= '0;
            end
            intensity_q <= '0;
            limit_q     <= '0;
            normal_q    <= 1'b0;
            test_q      <= 1'b0;
            word_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
`ifdef LEDMAT_RX_SEVENSEG_EN
            decode_q    <= '0;
`endif
        end else begin
            valid_q <= (state_q == ST_LATCH);
            err_q   <= err_d;
            if (state_q == ST_LATCH) begin
                word_q <= shreg_q;
                for (int i = 0; i < NUM_SEGS; i++) begin
                    if (addr == 8'(i + 1)) begin
                        digit_q[i] <= data;
                    end
                end
                case (addr)
`ifdef LEDMAT_RX_SEVENSEG_EN
                    8'h09: decode_q <= data[NUM_SEGS-1:0];
`endif
                    8'h0A: intensity_q <= data[3:0];
                    8'h0B: limit_q     <= (data[2:0] > LIMIT_MAX) ? LIMIT_MAX : data[2:0];
                    8'h0C: normal_q    <= data[0];
                    8'h0F: test_q      <= data[0];
                    default: ;
                endcase
            end
        end
    end

    assign bus.out_word       = word_q;
    assign bus.out_word_valid = valid_q;
    assign bus.out_frame_err  = err_q;

    // Slot counter is kept as (phase, sub) so the PWM phase needs no divider
    assign slot_wrap = (phase_q == 4'hF) && (sub_q == SUB_MAX);
    assign eff_limit = test_q ? LIMIT_MAX : limit_q;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            sub_q   <= '0;
            phase_q <= '0;
            idx_q   <= '0;
        end else begin
            if (sub_q == SUB_MAX) begin
                sub_q   <= '0;
                phase_q <= phase_q + 4'd1;
            end else begin
                sub_q <= sub_q + SUB_W'(1);
            end
            if (slot_wrap) begin
                idx_q <= (idx_q >= eff_limit) ? 3'd0 : idx_q + 3'd1;
            end
        end
    end

    always_comb begin
        cur_cols = digit_q[idx_q];
`ifdef LEDMAT_RX_SEVENSEG_EN
        if (decode_q[idx_q]) begin
            cur_cols = {digit_q[idx_q][7], seg7(digit_q[idx_q][3:0])};
        end
`endif
        rows_d = '0;
        cols_d = '0;
        if (test_q || normal_q) begin
            for (int i = 0; i < NUM_SEGS; i++) begin
                rows_d[i] = (idx_q == 3'(i));
            end
        end
        if (test_q) begin
            cols_d = '1;
        end else if (normal_q && (phase_q <= intensity_q)) begin
            cols_d = cur_cols;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            rows_q <= '0;
            cols_q <= '0;
        end else begin
            rows_q <= rows_d;
            cols_q <= cols_d;
        end
    end

    assign out_rows = rows_q;
    assign out_cols = cols_q;

endmodule

// File: tb/tb_ledmatrix_rx.sv
// Randomised scoreboard bench for ledmatrix_rx; a monitor pops expected word/error pulses,
// and the display is judged over whole scan periods against a register-level model.
module tb_ledmatrix_rx;

    localparam int NS = 8;
    localparam int SC = 64;

    logic       clk;
    logic       rst;
    logic [7:0] out_rows;
    logic [7:0] out_cols;

    ledmatrix_rx_if bus ();

    ledmatrix_rx #(
        .NUM_SEGS    (NS),
        .SCAN_CYCLES (SC)
    ) dut (
        .in_clk   (clk),
        .in_rst   (rst),
        .bus      (bus),
        .out_rows (out_rows),
        .out_cols (out_cols)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        is_err;
        logic [15:0] word;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] m_digit [NS];
    logic [7:0] m_decode;
    int         m_int;
    int         m_limit;
    bit         m_normal;
    bit         m_test;

`ifdef LEDMAT_RX_SEVENSEG_EN
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`endif

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m_digit[i] = 8'h00;
        m_decode = 8'h00;
        m_int    = 0;
        m_limit  = 0;
        m_normal = 1'b0;
        m_test   = 1'b0;
    endtask

    task automatic model_apply(input logic [15:0] w);
        int a;
        a = int'(w[15:8]);
        if (a >= 1 && a <= NS) m_digit[a-1] = w[7:0];
        else if (a == 9)  m_decode = w[7:0];
        else if (a == 10) m_int    = int'(w[3:0]);
        else if (a == 11) m_limit  = (int'(w[2:0]) > NS - 1) ? NS - 1 : int'(w[2:0]);
        else if (a == 12) m_normal = w[0];
        else if (a == 15) m_test   = w[0];
    endtask

    function automatic logic [7:0] exp_cols(input int i);
        logic [7:0] d;
        if (m_test) return 8'hFF;
        d = m_digit[i];
`ifdef LEDMAT_RX_SEVENSEG_EN
        if (m_decode[i]) d = {d[7], seg_tab[d[3:0]]};
`endif
        return d;
    endfunction

    // Scoreboard monitor: every word or error pulse must match the oldest outstanding frame
    always @(negedge clk) begin
        if (!rst && (bus.out_word_valid || bus.out_frame_err)) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: unexpected pulse valid=%0b err=%0b word=0x%04h",
                         bus.out_word_valid, bus.out_frame_err, bus.out_word);
            end else begin
                mon_e = sb_q.pop_front();
                if ((bus.out_frame_err !== mon_e.is_err) || (bus.out_word_valid !== !mon_e.is_err) ||
                    (!mon_e.is_err && bus.out_word !== mon_e.word)) begin
                    errors++;
                    $display("FAIL scoreboard: got valid=%0b err=%0b word=0x%04h, want err=%0b word=0x%04h",
                             bus.out_word_valid, bus.out_frame_err, bus.out_word, mon_e.is_err, mon_e.word);
                end
            end
        end
    end

    task automatic send_frame(input logic [31:0] bits, input int n);
        int   h;
        int   lat;
        exp_t e;
        h = int'($urandom_range(5, 3));
        bus.in_serial_clk = 1'b0;
        bus.in_seg_enable = 1'b1;
        repeat (h) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            bus.in_serial_data = bits[i];
            repeat (h) @(negedge clk);
            bus.in_serial_clk = 1'b1;
            repeat (h) @(negedge clk);
            bus.in_serial_clk = 1'b0;
        end
        repeat (h) @(negedge clk);
        bus.in_seg_enable = 1'b0;
        e.is_err = (n < 16);
        e.word   = bits[15:0];
        sb_q.push_back(e);
        if (n >= 16) model_apply(bits[15:0]);
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.out_word_valid || bus.out_frame_err) begin
                lat = k;
                break;
            end
        end
        if (n >= 16) chk("word latency", lat, 4);
        else         chk("frame error pulse seen", int'(lat > 0), 1);
        repeat ($urandom_range(2, 0)) @(negedge clk);
    endtask

    // Measures two full scan periods and compares row order, column values and duty per digit
    task automatic check_display(input string name);
        int         lim, inten, per, rows_bad, cols_bad, seq_bad, prev, idx;
        int         row_cnt [NS];
        int         on_cnt [NS];
        bit         on;
        logic [7:0] r, c;
        on    = m_test || m_normal;
        lim   = m_test ? NS - 1 : m_limit;
        inten = m_test ? 15 : m_int;
        per   = (lim + 1) * SC;
        rows_bad = 0; cols_bad = 0; seq_bad = 0; prev = -1;
        for (int i = 0; i < NS; i++) begin
            row_cnt[i] = 0;
            on_cnt[i]  = 0;
        end
        repeat (600) @(negedge clk);
        for (int t = 0; t < 2 * per; t++) begin
            @(negedge clk);
            r = out_rows;
            c = out_cols;
            if (!on) begin
                if (r != 8'h00 || c != 8'h00) rows_bad++;
            end else if ($countones(r) != 1) begin
                rows_bad++;
            end else begin
                idx = 0;
                for (int b = 0; b < NS; b++) if (r[b]) idx = b;
                if (idx > lim) begin
                    rows_bad++;
                end else begin
                    row_cnt[idx]++;
                    if (c != 8'h00) begin
                        on_cnt[idx]++;
                        if (c != exp_cols(idx)) cols_bad++;
                    end
                    if (prev >= 0 && idx != prev && idx != (prev + 1) % (lim + 1)) seq_bad++;
                    prev = idx;
                end
            end
        end
        chk({name, " bad rows"}, rows_bad, 0);
        if (on) begin
            chk({name, " bad cols"}, cols_bad, 0);
            chk({name, " scan order"}, seq_bad, 0);
            for (int i = 0; i <= lim; i++) begin
                chk($sformatf("%s row%0d time", name, i), row_cnt[i], 2 * SC);
                chk($sformatf("%s row%0d on time", name, i), on_cnt[i],
                    (exp_cols(i) != 8'h00) ? 2 * (inten + 1) * (SC / 16) : 0);
            end
        end
    endtask

    task automatic sample_row(input logic [7:0] row, output logic [7:0] val);
        val = 8'h00;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (out_rows == row && out_cols != 8'h00) begin
                val = out_cols;
                break;
            end
        end
    endtask

    function automatic logic [15:0] rand_word();
        int         sel;
        logic [7:0] a, d;
        sel = int'($urandom_range(15, 0));
        d   = 8'($urandom);
        case (sel)
            0:  a = 8'h00;
            9:  a = 8'h09;
            10: a = 8'h0A;
            11: a = 8'h0B;
            12: begin a = 8'h0C; d[0] = ($urandom_range(3, 0) != 0); end
            13: begin a = 8'h0F; d[0] = ($urandom_range(3, 0) == 0); end
            14: a = 8'($urandom_range(255, 13));
            default: a = 8'($urandom_range(8, 1));
        endcase
        if (a == 8'h0F && sel == 14) d[0] = 1'b0;
        return {a, d};
    endfunction

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  v;
        logic [31:0] b;
        int          n, kind;
        rst = 1'b1;
        bus.in_serial_clk  = 1'b0;
        bus.in_serial_data = 1'b0;
        bus.in_seg_enable  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset rows", out_rows, 0);
        chk("reset cols", out_cols, 0);
        chk("reset valid", bus.out_word_valid, 0);
        chk("reset err", bus.out_frame_err, 0);
        chk("reset word", bus.out_word, 0);
        rst = 1'b0;
        @(negedge clk);
        check_display("after reset");

        send_frame(32'h0000_0C01, 16);
        chk("word 0C01", bus.out_word, 16'h0C01);
        check_display("normal one digit");

        send_frame(32'h0000_0B07, 16);
        send_frame(32'h0000_0A0F, 16);
        send_frame(32'h0000_0155, 16);
        send_frame(32'h0000_08AA, 16);
        check_display("full scan");
        sample_row(8'h01, v);
        chk("row 0x01 cols", v, 8'h55);
        sample_row(8'h80, v);
        chk("row 0x80 cols", v, 8'hAA);

        send_frame(32'h0000_0A03, 16);
        check_display("quarter duty");

        send_frame(32'h0000_0377, 10);
        send_frame(32'h000A_0233, 20);
        chk("long frame word", bus.out_word, 16'h0233);
        check_display("after short and long frames");

        send_frame(32'h0000_0C00, 16);
        check_display("shutdown");
        send_frame(32'h0000_0F01, 16);
        check_display("display test");
        send_frame(32'h0000_0F00, 16);
        check_display("test off while shut down");

`ifdef LEDMAT_RX_SEVENSEG_EN
        send_frame(32'h0000_0C01, 16);
        send_frame(32'h0000_0901, 16);
        send_frame(32'h0000_0185, 16);
        sample_row(8'h01, v);
        chk("decoded digit 1", v, 8'hED);
        check_display("decode");
`endif

        for (int f = 0; f < 40; f++) begin
            kind = int'($urandom_range(9, 0));
            b    = $urandom;
            b[15:0] = rand_word();
            if (kind == 0)      n = int'($urandom_range(15, 1));
            else if (kind == 1) n = int'($urandom_range(24, 17));
            else                n = 16;
            send_frame(b, n);
            if (f % 8 == 7) check_display($sformatf("random %0d", f));
        end

        send_frame(32'h0000_0F01, 16);
        bus.in_seg_enable = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.in_serial_data = i[0];
            repeat (3) @(negedge clk);
            bus.in_serial_clk = 1'b1;
            repeat (3) @(negedge clk);
            bus.in_serial_clk = 1'b0;
        end
        rst = 1'b1;
        bus.in_seg_enable = 1'b0;
        model_reset();
        @(negedge clk);
        chk("mid-frame reset rows", out_rows, 0);
        chk("mid-frame reset cols", out_cols, 0);
        chk("mid-frame reset valid", bus.out_word_valid, 0);
        chk("mid-frame reset err", bus.out_frame_err, 0);
        chk("mid-frame reset word", bus.out_word, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send_frame(32'h0000_0C01, 16);
        chk("word after reset", bus.out_word, 16'h0C01);
        check_display("after mid-frame reset");

        repeat (20) @(negedge clk);
        chk("scoreboard drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ledmatrix_rx.md
# ledmatrix_rx

Serial-bus responder that emulates a MAX7219-style LED matrix / seven-segment controller. Sits on the far end of the `ledmatrix` driver's serial link: it shifts in 16-bit command words, decodes the register writes, and drives a multiplexed, brightness-modulated LED array. Used for on-FPGA loopback tests of the driver and for boards with bare LED matrices and no MAX7219.

## Interface
- `MAIN_CLK`, 50_000_000, system clock frequency in Hz.
- `BUS_BITS`, 16, word width: address byte (high) and data byte (low). Fixed at 16.
- `NUM_SEGS`, 8, number of digits/rows; at most 8.
- `LEDS_PER_SEG`, 8, LEDs per digit; fixed at 8.
- `SCAN_CYCLES`, MAIN_CLK/8000, `in_clk` cycles per digit scan slot; must be a multiple of 16.
- `in_clk`  in  1  system clock.
- `in_rst`  in  1  reset; asynchronous, active-high.
- `in_serial_clk`  in  1  serial clock, asynchronous to `in_clk`; data is sampled on the rising edge.
- `in_serial_data`  in  1  serial data, MSB first.
- `in_seg_enable`  in  1  chip select, active-high; the word is latched on deassertion.
- `out_rows`  out  NUM_SEGS  one-hot digit/row select, active-high.
- `out_cols`  out  LEDS_PER_SEG  segment/column drive, active-high.
- `out_word_valid`  out  1  one-cycle pulse when a word is latched.
- `out_frame_err`  out  1  one-cycle pulse when a frame with fewer than 16 bits is dropped.
- `out_word`  out  16  last latched word.

## Operation
- **Synchronisation:** each of `in_serial_clk`, `in_serial_data` and `in_seg_enable` passes through a 2-FF synchroniser. Edges are detected on the synchronised signals.
- **Receive FSM:**
  - Idle: wait for synchronised enable = 1, then go to Shift, clearing the bit counter.
  - Shift: on each rising serial-clock edge, shift data into a 16-bit register, LSB in. The bit counter saturates at 17.
  - Shift exit on falling enable: go to Latch if count ≥ 16; otherwise pulse `out_frame_err` and go to Idle.
  - Latch: write the register file, pulse `out_word_valid`, update `out_word`, go to Idle.
  - Frames longer than 16 bits keep the last 16 bits received (MAX7219 behaviour).
- **Register map** (address = bits 15:8):
  - 0x00: no-op.
  - 0x01–0x08: digit 1–8 data. Digits above NUM_SEGS are ignored.
  - 0x09: decode mask.
  - 0x0A: intensity; bits 3:0 used.
  - 0x0B: scan limit; bits 2:0 used, clamped to NUM_SEGS-1.
  - 0x0C: shutdown; bit 0, where 0 = shut down and 1 = normal.
  - 0x0F: display test; bit 0.
  - Any other address: ignored, but `out_word_valid` still pulses.
- **Reset values:**
  - Registers: all digits 0, decode 0, intensity 0, scan limit 0, shutdown = 0 (display off), test 0.
  - Outputs: `out_rows` 0, `out_cols` 0, `out_word_valid` 0, `out_frame_err` 0, `out_word` 0.
  - Receive FSM in Idle, scan counters 0.
- **Scan:**
  - Slot counter runs 0..SCAN_CYCLES-1. At wrap, the digit index advances 0..limit, then wraps to 0.
  - `out_rows` = one-hot of the digit index (bit 0 = digit 1).
  - If scan limit is lowered below the current index, the index goes to 0 at the next slot wrap.
- **Intensity PWM:** PWM phase = slot counter / (SCAN_CYCLES/16), range 0..15. Columns are driven only while phase ≤ intensity, giving a duty of (intensity+1)/16.
- **Columns:** `out_cols` = digit register bits 7:0; bit 0 = column 0.
- **Shutdown** (when test = 0): `out_rows` = 0 and `out_cols` = 0; registers stay writable.
- **Test:** overrides shutdown, scan limit and intensity. All digits are scanned, `out_cols` = all ones, duty is 16/16.

## Timing
- Serial clock high and low phases must each last ≥ 3 `in_clk` cycles. Enable must stay low ≥ 3 cycles between words.
- Latency from enable deassertion at the pin to the `out_word_valid` pulse: 4 `in_clk` cycles (2 sync, 1 edge detect, 1 Latch). Register contents are visible in the same cycle as the pulse.
- `out_rows` and `out_cols` are registered, one cycle behind the scan counters; they change only at slot or phase boundaries.
- A serial-clock rising edge detected in the same cycle as enable falling is discarded.
- An enable rise while in Latch is honoured: the FSM re-enters Shift on the next cycle from Idle with no lost edges, because Latch lasts one cycle.
- `in_rst` mid-frame: partial word discarded, all registers and outputs take their reset values immediately, no pulses.

## Configuration
- `LEDMAT_RX_SEVENSEG_EN` defined:
  - For digits whose decode-mask bit is set, data bits 3:0 pass through the codebase `sevenseg` decoder (ZERO_IS_ON=0, INVERSE_NUMBERING=0, ROTATED=0) onto columns 6:0.
  - Column 7 = data bit 7 (decimal point).
- Undefined: the decode mask is stored and readable via `out_word`, but ignored; columns always show raw data.

## Test plan
- Reset, then word 0x0C01: `out_word_valid` pulses 4 cycles after the enable fall; `out_word` = 0x0C01; display leaves shutdown, scanning digit 1 only.
- Words 0x0B07, 0x0A0F, 0x0155, 0x08AA: `out_rows` cycles 0x01..0x80 every SCAN_CYCLES; `out_cols` = 0x55 on row 0x01 and 0xAA on row 0x80 at 100% duty. With 0x0A03, columns are on for 4/16 of each slot.
- Frame of 10 bits: `out_frame_err` pulses, no `out_word_valid`, registers unchanged. Frame of 20 bits ending with 0x0233: digit 2 = 0x33.
- 0x0F01 while shut down: all rows scanned, `out_cols` = 0xFF. Then 0x0F00: `out_rows` = `out_cols` = 0.
- With `LEDMAT_RX_SEVENSEG_EN`: words 0x0901 and 0x0185 → digit 1 columns = 0x80 | sevenseg(5).
- Assert `in_rst` after 8 bits of a frame: all outputs 0 next cycle; a subsequent clean 0x0C01 latches correctly.
